// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg
//   Shared widths, ALU op encodings, pipeline state type and the
//   immediate-extend helper for the decode-side operand stage.
package id_operand_stage_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;
    localparam int IMMW = 16;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } pipe_state_e;

    function automatic logic [DW-1:0] imm_extend(input logic [IMMW-1:0] imm,
                                                 input logic            sign_ext);
        logic [DW-IMMW-1:0] upper;
        upper = sign_ext ? {(DW-IMMW){imm[IMMW-1]}} : '0;
        return {upper, imm};
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if
//   Valid/ready operand bus between the operand stage and the ALU.
//   master : operand stage (drives out_valid and payload, samples out_ready)
//   slave  : ALU / EX stage (samples payload, drives out_ready)
interface id_operand_stage_if;
    import id_operand_stage_pkg::*;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [2:0]    op_out;
    logic [AW-1:0] dest_out;
    logic          we_out;

    modport master (
        output out_valid,
        output a_out,
        output b_out,
        output op_out,
        output dest_out,
        output we_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  a_out,
        input  b_out,
        input  op_out,
        input  dest_out,
        input  we_out,
        output out_ready
    );

endinterface

// File: rtl/id_operand_stage_regfile_2r1w.sv
// regfile_2r1w
//   32-entry architectural register file, two asynchronous read ports and
//   one write port. R0 reads as zero and ignores writes. A read of the
//   index being written in the same cycle returns the incoming write data.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears storage)
//   ra_addr/ra_data   read port A
//   rb_addr/rb_data   read port B
//   wb_en/wb_addr/wb_data  write port
module regfile_2r1w
    import id_operand_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            mem[wb_addr] <= wb_data;
        end
    end

    // R0 check comes first so a write aimed at R0 can never be bypassed.
    always_comb begin
        ra_data = mem[ra_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (wb_en && (wb_addr == ra_addr)) begin
            ra_data = wb_data;
        end
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (wb_en && (wb_addr == rb_addr)) begin
            rb_data = wb_data;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage
//   Operand stage in front of the 32-bit ALU. Reads rs/rt from the register
//   file, selects operand B (register or extended immediate) and registers
//   operands, ALU op and destination info into a one-entry valid/ready slot.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake
//   rs, rt, imm, use_imm, sign_ext, op_in, dest_in, we_in   instruction fields
//   flush                   drop held entry and same-cycle input
//   wb_en/wb_addr/wb_data   register-file writeback
//   alu                     registered operand bus to the ALU (master side)
//
// Pipeline state
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no valid operands held; always ready
//   ST_FULL  | operands held for the ALU; ready only if drained
module id_operand_stage
    import id_operand_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    input  logic [IMMW-1:0]      imm,
    input  logic                 use_imm,
    input  logic                 sign_ext,
    input  logic [2:0]           op_in,
    input  logic [AW-1:0]        dest_in,
    input  logic                 we_in,
    input  logic                 flush,

    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [DW-1:0]        wb_data,

    id_operand_stage_if.master   alu
);

    pipe_state_e   state;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] b_sel;
    logic          accept;

    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [2:0]    op_q;
    logic [AW-1:0] dest_q;
    logic          we_q;

    regfile_2r1w u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs),
        .ra_data (rs_data),
        .rb_addr (rt),
        .rb_data (rt_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    assign b_sel = use_imm ? imm_extend(imm, sign_ext) : rt_data;

    // in_ready deliberately ignores in_valid and flush so upstream never
    // sees a combinational loop through its own request.
    assign in_ready = (state == ST_EMPTY) || alu.out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            dest_q <= '0;
            we_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (flush) begin
                        state <= ST_EMPTY;
                    end else if (alu.out_ready && !accept) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase

            // Payload only moves on accept, so a stalled entry stays
            // bit-stable even if its source registers are rewritten.
            if (accept) begin
                a_q    <= rs_data;
                b_q    <= b_sel;
                op_q   <= op_in;
                dest_q <= dest_in;
                we_q   <= we_in;
            end
        end
    end

    assign alu.out_valid = (state == ST_FULL);
    assign alu.a_out     = a_q;
    assign alu.b_out     = b_q;
    assign alu.op_out    = op_q;
    assign alu.dest_out  = dest_q;
    assign alu.we_out    = we_q;

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        use_imm;
    logic        sign_ext;
    logic [2:0]  op_in;
    logic [4:0]  dest_in;
    logic        we_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    id_operand_stage_if alu_if ();

    id_operand_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rs       (rs),
        .rt       (rt),
        .imm      (imm),
        .use_imm  (use_imm),
        .sign_ext (sign_ext),
        .op_in    (op_in),
        .dest_in  (dest_in),
        .we_in    (we_in),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .alu      (alu_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic        m_valid = 1'b0;
    int          errors  = 0;
    int          checks  = 0;

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_en && (wb_addr == idx)) return wb_data;
        return mregs[idx];
    endfunction

    // Reference model and scoreboard, evaluated on the falling edge while
    // inputs are stable for the upcoming rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic acc;
        logic exp_ready;
        if (!rst_n) begin
            m_valid = 1'b0;
            sb.delete();
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else begin
            exp_ready = !m_valid || alu_if.out_ready;
            checks++;
            if (alu_if.out_valid !== m_valid) begin
                errors++;
                $display("FAIL out_valid_track t=%0t: got %b want %b", $time, alu_if.out_valid, m_valid);
            end
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready_track t=%0t: got %b want %b", $time, in_ready, exp_ready);
            end
            if (m_valid && (flush || alu_if.out_ready)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow t=%0t: output with no expected entry", $time);
                end else begin
                    e = sb.pop_front();
                    if (!flush) begin
                        checks++;
                        if ({alu_if.a_out, alu_if.b_out, alu_if.op_out, alu_if.dest_out, alu_if.we_out} !== e) begin
                            errors++;
                            $display("FAIL sb_payload t=%0t: got a=%h b=%h op=%0d dest=%0d we=%b want a=%h b=%h op=%0d dest=%0d we=%b",
                                     $time, alu_if.a_out, alu_if.b_out, alu_if.op_out, alu_if.dest_out, alu_if.we_out,
                                     e.a, e.b, e.op, e.dest, e.we);
                        end
                    end
                end
            end
            acc = in_valid && exp_ready && !flush;
            if (acc) begin
                e.a    = model_read(rs);
                e.b    = use_imm ? (sign_ext ? {{16{imm[15]}}, imm} : {16'h0, imm}) : model_read(rt);
                e.op   = op_in;
                e.dest = dest_in;
                e.we   = we_in;
                sb.push_back(e);
            end
            if (flush)                  m_valid = 1'b0;
            else if (acc)               m_valid = 1'b1;
            else if (alu_if.out_ready)  m_valid = 1'b0;
            if (wb_en && (wb_addr != 5'd0)) mregs[wb_addr] = wb_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        rs       = '0;
        rt       = '0;
        imm      = '0;
        use_imm  = 1'b0;
        sign_ext = 1'b0;
        op_in    = '0;
        dest_in  = '0;
        we_in    = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
    endtask

    task automatic issue(input logic [4:0] r_s, input logic [4:0] r_t, input logic [15:0] im,
                         input logic ui, input logic se, input logic [2:0] op,
                         input logic [4:0] d, input logic w);
        in_valid = 1'b1;
        rs       = r_s;
        rt       = r_t;
        imm      = im;
        use_imm  = ui;
        sign_ext = se;
        op_in    = op;
        dest_in  = d;
        we_in    = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_if.out_ready = 1'b0;
        step();
        step();
        checks++;
        if (alu_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b want 0", alu_if.out_valid);
        end
        checks++;
        if ({alu_if.a_out, alu_if.b_out, alu_if.op_out, alu_if.dest_out, alu_if.we_out} !== 73'h0) begin
            errors++; $display("FAIL rst_payload: got a=%h b=%h op=%0d dest=%0d we=%b want all zero",
                               alu_if.a_out, alu_if.b_out, alu_if.op_out, alu_if.dest_out, alu_if.we_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        alu_if.out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055; step();
        wb_addr = 5'd9; wb_data = 32'h0000_0099; step();
        idle();
        alu_if.out_ready = 1'b0;
        issue(5'd5, 5'd9, 16'h0, 1'b0, 1'b0, OP_ADD, 5'd1, 1'b1);
        step();
        idle();
        checks++;
        if (alu_if.out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_setup: got out_valid %b want 1", alu_if.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (alu_if.out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_async: got out_valid %b in_ready %b want 0 1", alu_if.out_valid, in_ready);
        end
        step();
        rst_n = 1'b1;
        alu_if.out_ready = 1'b1;
        issue(5'd5, 5'd9, 16'h0, 1'b0, 1'b0, OP_ADD, 5'd2, 1'b1);
        step();
        idle();
        checks++;
        if (alu_if.out_valid !== 1'b1 || alu_if.a_out !== 32'h0 || alu_if.b_out !== 32'h0) begin
            errors++; $display("FAIL rst_then_read: got v=%b a=%h b=%h want v=1 a=0 b=0",
                               alu_if.out_valid, alu_if.a_out, alu_if.b_out);
        end
        step();
    endtask

    task automatic test_bypass();
        alu_if.out_ready = 1'b1;
        issue(5'd3, 5'd0, 16'h0, 1'b0, 1'b0, OP_OR, 5'd3, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        step();
        idle();
        checks++;
        if (alu_if.a_out !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", alu_if.a_out);
        end
        issue(5'd0, 5'd3, 16'h0, 1'b0, 1'b0, OP_AND, 5'd4, 1'b0);
        rs = 5'd3;
        step();
        idle();
        checks++;
        if (alu_if.a_out !== 32'hDEAD_BEEF || alu_if.b_out !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_stored: got a=%h b=%h want deadbeef deadbeef", alu_if.a_out, alu_if.b_out);
        end
        step();
    endtask

    task automatic test_r0();
        alu_if.out_ready = 1'b1;
        issue(5'd0, 5'd0, 16'h0, 1'b0, 1'b0, OP_ADD, 5'd0, 1'b0);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        idle();
        checks++;
        if (alu_if.a_out !== 32'h0 || alu_if.b_out !== 32'h0) begin
            errors++; $display("FAIL r0_bypass: got a=%h b=%h want 0 0", alu_if.a_out, alu_if.b_out);
        end
        issue(5'd0, 5'd0, 16'h0, 1'b0, 1'b0, OP_ADD, 5'd0, 1'b0);
        step();
        idle();
        checks++;
        if (alu_if.a_out !== 32'h0) begin
            errors++; $display("FAIL r0_stored: got %h want 0", alu_if.a_out);
        end
        step();
    endtask

    task automatic test_imm();
        alu_if.out_ready = 1'b1;
        issue(5'd0, 5'd3, 16'h8001, 1'b1, 1'b1, OP_ADD, 5'd6, 1'b1);
        step();
        checks++;
        if (alu_if.b_out !== 32'hFFFF_8001) begin
            errors++; $display("FAIL imm_sext: got %h want ffff8001", alu_if.b_out);
        end
        issue(5'd0, 5'd3, 16'h8001, 1'b1, 1'b0, OP_ADD, 5'd6, 1'b1);
        step();
        checks++;
        if (alu_if.b_out !== 32'h0000_8001) begin
            errors++; $display("FAIL imm_zext: got %h want 00008001", alu_if.b_out);
        end
        issue(5'd0, 5'd3, 16'h7FFF, 1'b1, 1'b1, OP_SLT, 5'd7, 1'b1);
        step();
        idle();
        checks++;
        if (alu_if.b_out !== 32'h0000_7FFF || alu_if.op_out !== OP_SLT) begin
            errors++; $display("FAIL imm_sext_pos: got b=%h op=%0d want 00007fff 7", alu_if.b_out, alu_if.op_out);
        end
        step();
    endtask

    task automatic test_stall();
        alu_if.out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
        step();
        idle();
        alu_if.out_ready = 1'b0;
        issue(5'd7, 5'd0, 16'h0005, 1'b1, 1'b0, OP_OR, 5'd4, 1'b1);
        step();
        issue(5'd7, 5'd7, 16'h0, 1'b0, 1'b0, OP_SUB, 5'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hAAAA_0000 + 32'(i);
            step();
            checks++;
            if (in_ready !== 1'b0 || alu_if.out_valid !== 1'b1 || alu_if.a_out !== 32'h0000_1234 ||
                alu_if.b_out !== 32'h0000_0005 || alu_if.op_out !== OP_OR) begin
                errors++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b a=%h b=%h op=%0d want 0 1 00001234 00000005 1",
                                   i, in_ready, alu_if.out_valid, alu_if.a_out, alu_if.b_out, alu_if.op_out);
            end
        end
        wb_en = 1'b0;
        alu_if.out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        step();
        idle();
        checks++;
        if (alu_if.out_valid !== 1'b1 || alu_if.a_out !== 32'hAAAA_0002 || alu_if.b_out !== 32'hAAAA_0002 ||
            alu_if.op_out !== OP_SUB) begin
            errors++; $display("FAIL stall_next_load: got v=%b a=%h b=%h op=%0d want 1 aaaa0002 aaaa0002 6",
                               alu_if.out_valid, alu_if.a_out, alu_if.b_out, alu_if.op_out);
        end
        step();
    endtask

    task automatic test_flush();
        alu_if.out_ready = 1'b1;
        issue(5'd1, 5'd2, 16'h0, 1'b0, 1'b0, OP_AND, 5'd6, 1'b1);
        flush = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h00C0_FFEE;
        step();
        idle();
        checks++;
        if (alu_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop: got out_valid %b want 0", alu_if.out_valid);
        end
        issue(5'd12, 5'd0, 16'h0, 1'b0, 1'b0, OP_ADD, 5'd8, 1'b1);
        step();
        idle();
        checks++;
        if (alu_if.out_valid !== 1'b1 || alu_if.a_out !== 32'h00C0_FFEE || alu_if.dest_out !== 5'd8) begin
            errors++; $display("FAIL flush_wb_kept: got v=%b a=%h dest=%0d want 1 00c0ffee 8",
                               alu_if.out_valid, alu_if.a_out, alu_if.dest_out);
        end
        alu_if.out_ready = 1'b0;
        step();
        flush = 1'b1;
        issue(5'd3, 5'd3, 16'h0, 1'b0, 1'b0, OP_SUB, 5'd9, 1'b1);
        step();
        idle();
        checks++;
        if (alu_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_held: got out_valid %b want 0", alu_if.out_valid);
        end
        step();
        alu_if.out_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5];
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB; ops[4] = OP_SLT;
        alu_if.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom()),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)],
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom();
            step();
            checks++;
            if (alu_if.out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, alu_if.out_valid);
            end
        end
        for (int i = 0; i < 40; i++) begin
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom()),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)],
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            in_valid         = 1'($urandom_range(0, 1));
            alu_if.out_ready = 1'($urandom_range(0, 1));
            wb_en            = 1'($urandom_range(0, 1));
            wb_addr          = 5'($urandom_range(0, 31));
            wb_data          = $urandom();
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_r0();
        test_imm();
        test_stall();
        test_flush();
        test_back_to_back();
        alu_if.out_ready = 1'b1;
        idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL drain: got %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
